mux4way16_arbiter: RTL
======================

MUX4WAY16_ARBITER -- requirements
Module: mux4way16_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, meaning the maximum number of consecutive cycles one requester keeps the grant while others wait (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, [0:3], per-requester request; bit i belongs to requester i.
REQ-005 SHALL have ports a, b, c, d, input, [0:15] each, data of requesters 0, 1, 2 and 3.
REQ-006 SHALL have port grant, output, [0:3], registered one-hot grant; all zero when idle.
REQ-007 SHALL have port sel, output, 2, registered index of the granted requester.
REQ-008 SHALL have port valid, output, 1, registered; high exactly when grant is non-zero.
REQ-009 SHALL have port y, output, [0:15], data of the granted requester; 16'h0000 when valid is low.

Function
REQ-010 SHALL implement the two-state FSM IDLE and GRANT, with valid high exactly in GRANT.
REQ-011 IDLE: if req is non-zero at an edge, SHALL enter GRANT at that edge with the round-robin winner; otherwise it SHALL stay in IDLE.
REQ-012 Round-robin SHALL search req starting at index (ptr+1) mod 4 and wrapping 3->0; the winner is the first set bit found.
REQ-013 ptr SHALL update to the winner index on every new grant.
REQ-014 Latency SHALL be exactly one cycle: req sampled at edge n gives grant/sel/valid at edge n.
REQ-015 GRANT: while req[sel] stays high, grant SHALL hold (lock), subject to REQ-023.
REQ-016 GRANT: if req[sel] is low at an edge and another req bit is set, SHALL re-arbitrate from (sel+1) mod 4 and switch grant at that edge with no idle bubble.
REQ-017 GRANT: if req is all zero at an edge, SHALL return to IDLE; grant=0, valid=0, and ptr keeps its value.
REQ-018 y SHALL be the combinational mux of a/b/c/d selected by registered sel, ANDed with valid.
REQ-019 A request dropped and re-raised in the same cycle as its grant SHALL NOT be distinguished; only levels at clock edges matter.
REQ-020 grant SHALL never have more than one bit set, and SHALL never have a bit set whose req bit was low at the granting edge.

Reset
REQ-021 When rst is high at an edge, SHALL force state=IDLE, grant=0, sel=0, valid=0 and ptr=3 (first search starts at 0), overriding all other behaviour including mid-grant.
REQ-022 The cycle after rst deasserts SHALL arbitrate normally per REQ-011.

Configuration
REQ-023 With ARB_TIMEOUT_EN defined, SHALL keep a hold counter that clears on every new grant and increments each GRANT cycle; when it reaches HOLD_MAX-1 with req[sel] high and another req bit set, the next edge SHALL rotate the grant per REQ-016. With no competing request the counter SHALL saturate and the grant SHALL hold.
REQ-024 Without ARB_TIMEOUT_EN, SHALL contain no hold counter; HOLD_MAX SHALL be ignored and locking per REQ-015 SHALL be unbounded.

Structure
REQ-025 The shared package SHALL hold the FSM state encodings (IDLE=0, GRANT=1) and the default HOLD_MAX constant.
REQ-026 The data path SHALL be one sub-module, mux4way16_gate (a, b, c, d, sel -> y), with the valid gating applied in the arbiter.

Verification
REQ-027 rst=1 for 2 cycles, then req=0000 -> grant=0000, valid=0, y=16'h0000.
REQ-028 After reset, req=0110, a..d=16'h1111/2222/3333/4444 -> next edge grant=0100, sel=1, y=16'h2222; hold req 3 cycles -> grant unchanged.
REQ-029 Granted 1 with req=0111, drop req[1] -> next edge grant=0010, sel=2, y=16'h3333, no valid gap; then req=0000 -> IDLE, valid=0.
REQ-030 ARB_TIMEOUT_EN with HOLD_MAX=4, req=1001 held -> grant 0 for 4 cycles, then 3 for 4 cycles, alternating; with req=1000 only, grant 0 holds indefinitely.
REQ-031 rst asserted mid-GRANT with req=1111 -> next edge grant=0; rst released -> next edge grant=1000 (ptr=3 search).
REQ-032 Random req for 1000 cycles -> grant one-hot or zero, grant always a subset of req at the granting edge, and no requester waits more than 3 grant changes while its req stays high.

Source files
------------

// File: rtl/mux4way16_arbiter_pkg.sv
// Shared types and helpers for the 4-way 16-bit arbitrated mux.
// FSM encoding, default hold limit, round-robin pick.
package mux4way16_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned HOLD_MAX_DEF = 8;

  function automatic logic [0:3] onehot4(logic [1:0] idx);
    logic [0:3] o;
    o      = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

  // First set bit searching from last+1, wrapping 3 -> 0.
  // Walking k downward lets the nearest candidate win.
  function automatic logic [1:0] rr_pick(logic [0:3] r,
                                         logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4way16_arbiter_gate.sv
// Plain 4:1 16-bit data mux; no gating here.
// The arbiter applies the valid mask.
module mux4way16_gate (
  input  logic [0:15] a,
  input  logic [0:15] b,
  input  logic [0:15] c,
  input  logic [0:15] d,
  input  logic [1:0]  sel,
  output logic [0:15] y
);

  // Select one requester's data word.
  always_comb begin
    y = a;
    unique case (sel)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mux4way16_arbiter.sv
// Round-robin arbiter driving a 4-way 16-bit mux.
// Optional hold timeout: define ARB_TIMEOUT_EN.
module mux4way16_arbiter
  import mux4way16_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:3]  req,
  input  logic [0:15] a,
  input  logic [0:15] b,
  input  logic [0:15] c,
  input  logic [0:15] d,
  output logic [0:3]  grant,
  output logic [1:0]  sel,
  output logic        valid,
  output logic [0:15] y
);

  state_e     state_q;
  logic [0:3] grant_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;
  logic       valid_q;
  logic [1:0] win_idle;
  logic [1:0] win_rot;
  logic       keep;
  logic [0:15] mux_y;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW =
    (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HLIM = HW'(HOLD_MAX - 1);

  logic [HW-1:0] hold_q;
  logic          others;
  logic          expire;

  // Owner loses the lock once its budget is spent
  // and someone else is waiting.
  always_comb begin
    others = |(req & ~onehot4(sel_q));
    expire = (hold_q == HLIM) && others;
  end
`else
  // HOLD_MAX only matters with the timeout feature.
  logic unused_hold;
  assign unused_hold = ^HOLD_MAX;
`endif

  // Candidate winners and the lock decision.
  always_comb begin
    win_idle = rr_pick(req, ptr_q);
    win_rot  = rr_pick(req, sel_q);
`ifdef ARB_TIMEOUT_EN
    keep     = req[sel_q] && !expire;
`else
    keep     = req[sel_q];
`endif
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            grant_q <= onehot4(win_idle);
            sel_q   <= win_idle;
            ptr_q   <= win_idle;
            valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end
        end
        GRANT: begin
          if (req == '0) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
          end else if (keep) begin
`ifdef ARB_TIMEOUT_EN
            if (hold_q != HLIM)
              hold_q <= hold_q + 1'b1;
`endif
          end else begin
            grant_q <= onehot4(win_rot);
            sel_q   <= win_rot;
            ptr_q   <= win_rot;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  mux4way16_gate u_gate (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel_q),
    .y   (mux_y)
  );

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign y     = valid_q ? mux_y : 16'h0000;

endmodule
